// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one or two stop bits,
// with bit boundaries taken from rising edges of BaudOut. Parity support: define UART_TX_PARITY_EN.
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  BaudOut,
    input  logic                  Send,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic [1:0]            ParityType,
    input  logic                  StopBits,
    output logic                  DataOut,
    output logic                  Busy,
    output logic                  Done
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } state_t;

    state_t                state_q, state_d;
    logic                  baud_prev_q, baud_prev_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]      next_cnt;
    logic [DATA_WIDTH-1:0] shadow_data_q, shadow_data_d;
    logic                  shadow_stop_q, shadow_stop_d;
    logic                  data_out_q, data_out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tick;

`ifdef UART_TX_PARITY_EN
    logic [1:0]            shadow_ptype_q, shadow_ptype_d;
    logic                  has_parity;
    logic                  parity_bit;

    assign has_parity = (shadow_ptype_q == 2'b01) || (shadow_ptype_q == 2'b10);
    assign parity_bit = (shadow_ptype_q == 2'b01) ? ~(^shadow_data_q) : ^shadow_data_q;
`else
    logic                  unused_parity_type;

    assign unused_parity_type = ^ParityType;
`endif

    assign tick     = BaudOut & ~baud_prev_q;
    assign next_cnt = bit_cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        baud_prev_d   = BaudOut;
        bit_cnt_d     = bit_cnt_q;
        shadow_data_d = shadow_data_q;
        shadow_stop_d = shadow_stop_q;
        data_out_d    = data_out_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
`ifdef UART_TX_PARITY_EN
        shadow_ptype_d = shadow_ptype_q;
`endif

        case (state_q)
            ST_IDLE: begin
                data_out_d = 1'b1;
                busy_d     = 1'b0;
                if (Send) begin
                    shadow_data_d = DataIn;
                    shadow_stop_d = StopBits;
`ifdef UART_TX_PARITY_EN
                    shadow_ptype_d = ParityType;
`endif
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                data_out_d = 1'b1;
                if (tick) begin
                    data_out_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_cnt_d  = '0;
                    data_out_d = shadow_data_q[0];
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        if (has_parity) begin
                            data_out_d = parity_bit;
                            state_d    = ST_PARITY;
                        end else begin
                            data_out_d = 1'b1;
                            state_d    = ST_STOP1;
                        end
`else
                        data_out_d = 1'b1;
                        state_d    = ST_STOP1;
`endif
                    end else begin
                        bit_cnt_d  = next_cnt;
                        data_out_d = shadow_data_q[next_cnt];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    data_out_d = 1'b1;
                    state_d    = ST_STOP1;
                end
            end
`endif
            ST_STOP1: begin
                if (tick) begin
                    data_out_d = 1'b1;
                    if (shadow_stop_q) begin
                        state_d = ST_STOP2;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STOP2: begin
                if (tick) begin
                    data_out_d = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                data_out_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            baud_prev_q   <= 1'b0;
            bit_cnt_q     <= '0;
            shadow_data_q <= '0;
            shadow_stop_q <= 1'b0;
            data_out_q    <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef UART_TX_PARITY_EN
            shadow_ptype_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            baud_prev_q   <= baud_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            shadow_data_q <= shadow_data_d;
            shadow_stop_q <= shadow_stop_d;
            data_out_q    <= data_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef UART_TX_PARITY_EN
            shadow_ptype_q <= shadow_ptype_d;
`endif
        end
    end

    assign DataOut = data_out_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule
